lock_relock_fsm: RTL and testbench

Lock-acquisition supervisor that sits on the control side of `lock_pid_block`. It watches the loop error and the PID output, and drives the PID's integrator-reset and freeze inputs plus a search-sweep offset. Together these acquire lock, declare lock, detect loss of lock and re-acquire it automatically. It runs in the lock-in/PID FPGA fabric on the same clock as the PID and is configured from the register bank.

---
 rtl/lock_relock_fsm.sv | 170 +++++++++++++++++
 tb/tb_lock_relock_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lock_relock_fsm.sv
// Lock-acquisition supervisor for lock_pid_block: sweeps to find lock, declares lock,
// detects loss of lock and re-acquires automatically.
module lock_relock_fsm (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               enable_i,
    input  logic signed [13:0] err_i,
    input  logic signed [13:0] ctrl_i,
    input  logic [13:0]        err_thr_i,
    input  logic [13:0]        rail_thr_i,
    input  logic [15:0]        lock_cnt_i,
    input  logic [15:0]        lost_cnt_i,
    input  logic [15:0]        hold_len_i,
    input  logic signed [13:0] sweep_min_i,
    input  logic signed [13:0] sweep_max_i,
    input  logic [13:0]        sweep_step_i,
    output logic               int_rst_o,
    output logic               pid_freeze_o,
    output logic               pid_ifreeze_o,
    output logic signed [13:0] sweep_o,
    output logic               locked_o,
    output logic [2:0]         state_o,
    output logic [15:0]        relock_cnt_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SWEEP   = 3'd1,
        ACQUIRE = 3'd2,
        LOCKED  = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic signed [13:0] sweep_nxt;
    logic               dir_up, dir_nxt;
    logic [15:0]        cnt, cnt_nxt, cnt_inc;
    logic [15:0]        relock_nxt;
    logic [15:0]        lock_tgt, lost_tgt, hold_tgt;
    logic [14:0]        err_mag, ctrl_mag;
    logic               err_ok, good;
    logic signed [14:0] sw_ext, step_ext, sw_sum, min_ext, max_ext;

    // Magnitude in 15 bits so that -8192 maps to 8192 rather than wrapping.
    function automatic logic [14:0] mag15(input logic signed [13:0] x);
        logic [14:0] w;
        w = {x[13], x};
        return x[13] ? (~w + 15'd1) : w;
    endfunction

    assign err_mag  = mag15(err_i);
    assign ctrl_mag = mag15(ctrl_i);
    assign err_ok   = err_mag <= {1'b0, err_thr_i};
    assign good     = err_ok && (ctrl_mag < {1'b0, rail_thr_i});

    assign lock_tgt = (lock_cnt_i == 16'd0) ? 16'd1 : lock_cnt_i;
    assign lost_tgt = (lost_cnt_i == 16'd0) ? 16'd1 : lost_cnt_i;
    assign hold_tgt = (hold_len_i == 16'd0) ? 16'd1 : hold_len_i;
    assign cnt_inc  = cnt + 16'd1;

    assign sw_ext   = {sweep_o[13], sweep_o};
    assign step_ext = {1'b0, sweep_step_i};
    assign min_ext  = {sweep_min_i[13], sweep_min_i};
    assign max_ext  = {sweep_max_i[13], sweep_max_i};
    assign sw_sum   = dir_up ? (sw_ext + step_ext) : (sw_ext - step_ext);

    assign state_o  = state;

    always_comb begin
        state_nxt  = state;
        sweep_nxt  = sweep_o;
        dir_nxt    = dir_up;
        cnt_nxt    = cnt;
        relock_nxt = relock_cnt_o;
        if (!enable_i) begin
            state_nxt = IDLE;
            sweep_nxt = '0;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = SWEEP;
                    sweep_nxt = sweep_min_i;
                    dir_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end
                SWEEP: begin
                    // Capture freezes the sweep on the very cycle it is seen.
                    if (err_ok) begin
                        state_nxt = ACQUIRE;
                        cnt_nxt   = '0;
                    end else if (sweep_min_i > sweep_max_i) begin
                        sweep_nxt = sweep_min_i;
                    end else if (sweep_step_i != 14'd0) begin
                        if (sw_sum >= max_ext) begin
                            sweep_nxt = sweep_max_i;
                            dir_nxt   = 1'b0;
                        end else if (sw_sum <= min_ext) begin
                            sweep_nxt = sweep_min_i;
                            dir_nxt   = 1'b1;
                        end else begin
                            sweep_nxt = sw_sum[13:0];
                        end
                    end
                end
                ACQUIRE: begin
                    if (!good) begin
                        state_nxt = SWEEP;
                        cnt_nxt   = '0;
                    end else if (cnt_inc >= lock_tgt) begin
                        state_nxt = LOCKED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        cnt_nxt = '0;
                    end else if (cnt_inc >= lost_tgt) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                        if (relock_cnt_o != 16'hFFFF) relock_nxt = relock_cnt_o + 16'd1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                HOLD: begin
                    if (cnt_inc >= hold_tgt) begin
                        state_nxt = SWEEP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    sweep_nxt = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // PID control outputs are decoded from the next state so they align with state_o.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            sweep_o       <= '0;
            dir_up        <= 1'b1;
            cnt           <= '0;
            relock_cnt_o  <= '0;
            int_rst_o     <= 1'b1;
            pid_ifreeze_o <= 1'b1;
            pid_freeze_o  <= 1'b0;
            locked_o      <= 1'b0;
        end else begin
            state         <= state_nxt;
            sweep_o       <= sweep_nxt;
            dir_up        <= dir_nxt;
            cnt           <= cnt_nxt;
            relock_cnt_o  <= relock_nxt;
            int_rst_o     <= (state_nxt == IDLE) || (state_nxt == SWEEP);
            pid_ifreeze_o <= (state_nxt == IDLE) || (state_nxt == SWEEP) || (state_nxt == HOLD);
            pid_freeze_o  <= (state_nxt == HOLD);
            locked_o      <= (state_nxt == LOCKED);
        end
    end

endmodule

// File: tb/tb_lock_relock_fsm.sv
// Table-driven bench for lock_relock_fsm: each vector's expected outputs go into a
// scoreboard queue when driven and are popped one clock later.
module tb_lock_relock_fsm;

    logic               clk = 1'b0;
    logic               rstn;
    logic               enable;
    logic signed [13:0] err, ctrl, sweep_min, sweep_max;
    logic [13:0]        err_thr, rail_thr, sweep_step;
    logic [15:0]        lock_cnt, lost_cnt, hold_len;
    logic               int_rst, pid_freeze, pid_ifreeze, locked;
    logic signed [13:0] sweep;
    logic [2:0]         state;
    logic [15:0]        relock_cnt;

    localparam int W = 37;
    logic [W-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic               en;
        logic signed [13:0] err;
        logic signed [13:0] ctrl;
        logic [13:0]        thr;
        logic [15:0]        lk;
        logic signed [13:0] smin;
        logic signed [13:0] smax;
        logic [13:0]        step;
        logic [2:0]         st;
        logic signed [13:0] sw;
        logic [15:0]        rl;
    } vec_t;
    vec_t vecs[$];

    lock_relock_fsm dut (
        .clk_i(clk), .rstn_i(rstn), .enable_i(enable),
        .err_i(err), .ctrl_i(ctrl), .err_thr_i(err_thr), .rail_thr_i(rail_thr),
        .lock_cnt_i(lock_cnt), .lost_cnt_i(lost_cnt), .hold_len_i(hold_len),
        .sweep_min_i(sweep_min), .sweep_max_i(sweep_max), .sweep_step_i(sweep_step),
        .int_rst_o(int_rst), .pid_freeze_o(pid_freeze), .pid_ifreeze_o(pid_ifreeze),
        .sweep_o(sweep), .locked_o(locked), .state_o(state), .relock_cnt_o(relock_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Per-state flags {int_rst, ifreeze, freeze, locked} from the state table.
    function automatic logic [3:0] flags_of(input logic [2:0] st);
        case (st)
            3'd0, 3'd1: return 4'b1100;
            3'd2:       return 4'b0000;
            3'd3:       return 4'b0001;
            3'd4:       return 4'b0110;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [W-1:0] pack(input logic [2:0] st, input logic [13:0] sw,
                                          input logic [15:0] rl);
        return {st, sw, flags_of(st), rl};
    endfunction

    function automatic vec_t mk(input logic en, input int e, input int st, input int sw,
                                input int rl, input int c = 0, input int thr = 5,
                                input int lk = 4, input int smin = -100,
                                input int smax = 100, input int step = 50);
        vec_t v;
        v.en = en;         v.err = 14'(e);     v.ctrl = 14'(c);   v.thr = 14'(thr);
        v.lk = 16'(lk);    v.smin = 14'(smin); v.smax = 14'(smax); v.step = 14'(step);
        v.st = 3'(st);     v.sw = 14'(sw);     v.rl = 16'(rl);
        return v;
    endfunction

    function automatic void pv(input logic en, input int e, input int st, input int sw,
                               input int rl, input int c = 0, input int thr = 5,
                               input int lk = 4, input int smin = -100,
                               input int smax = 100, input int step = 50);
        vecs.push_back(mk(en, e, st, sw, rl, c, thr, lk, smin, smax, step));
    endfunction

    task automatic compare(input string name);
        logic [W-1:0] act, exp_v;
        act = {state, sweep, int_rst, pid_ifreeze, pid_freeze, locked, relock_cnt};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, got state %0d required an entry", name, state);
        end else begin
            exp_v = exp_q.pop_front();
            if (act !== exp_v) begin
                n_miss++;
                $display("FAIL %s: state/sweep/flags/relock got %0d/%0d/%b/%0d required %0d/%0d/%b/%0d",
                         name, act[36:34], $signed(act[33:20]), act[19:16], act[15:0],
                         exp_v[36:34], $signed(exp_v[33:20]), exp_v[19:16], exp_v[15:0]);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        enable = v.en; err = v.err; ctrl = v.ctrl; err_thr = v.thr; lock_cnt = v.lk;
        sweep_min = v.smin; sweep_max = v.smax; sweep_step = v.step;
        exp_q.push_back(pack(v.st, v.sw, v.rl));
        @(posedge clk);
        @(negedge clk);
        compare(name);
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; err = 14'sd1000; ctrl = '0; err_thr = 14'd5;
        rail_thr = 14'd8000; lock_cnt = 16'd4; lost_cnt = 16'd3; hold_len = 16'd2;
        sweep_min = -14'sd100; sweep_max = 14'sd100; sweep_step = 14'd50;

        // Sweep -100..100 with err held large.
        pv(0, 1000, 0, 0, 0);
        pv(1, 1000, 1, -100, 0);
        pv(1, 1000, 1, -50, 0);
        pv(1, 1000, 1, 0, 0);
        pv(1, 1000, 1, 50, 0);
        pv(1, 1000, 1, 100, 0);
        pv(1, 1000, 1, 50, 0);
        pv(1, 1000, 1, 0, 0);
        // Capture at 0, four good cycles to LOCKED.
        pv(1, 3, 2, 0, 0);
        for (int i = 0; i < 3; i++) pv(1, 3, 2, 0, 0);
        pv(1, 3, 3, 0, 0);
        // Loss: 2 bad, 1 good, 3 bad -> HOLD for 2 cycles -> SWEEP.
        pv(1, 1000, 3, 0, 0);
        pv(1, 1000, 3, 0, 0);
        pv(1, 3, 3, 0, 0);
        pv(1, 1000, 3, 0, 0);
        pv(1, 1000, 3, 0, 0);
        pv(1, 1000, 4, 0, 1);
        pv(1, 1000, 4, 0, 1);
        pv(1, 1000, 1, 0, 1);
        pv(1, 1000, 1, -50, 1);
        // Rail hit in ACQUIRE: back to SWEEP, value held, direction still down.
        pv(1, 3, 2, -50, 1);
        pv(1, 3, 1, -50, 1, 8000);
        pv(1, 1000, 1, -100, 1);
        pv(1, 1000, 1, -50, 1);
        // No abs wrap: |-8192| exceeds 8191, |-8191| does not.
        pv(1, -8192, 1, 0, 1, 0, 8191);
        pv(1, -8191, 2, 0, 1, 0, 8191);
        pv(1, -8192, 1, 0, 1, 0, 8191);
        // Relock, then disable in LOCKED keeps relock count.
        pv(1, 3, 2, 0, 1);
        for (int i = 0; i < 3; i++) pv(1, 3, 2, 0, 1);
        pv(1, 3, 3, 0, 1);
        pv(0, 3, 0, 0, 1);
        pv(0, 1000, 0, 0, 1);
        // lock_cnt = 0 behaves as 1.
        pv(1, 1000, 1, -100, 1);
        pv(1, 3, 2, -100, 1);
        pv(1, 3, 3, -100, 1, 0, 5, 0);
        pv(0, 3, 0, 0, 1);
        // Inverted bounds hold min; zero step holds value.
        for (int i = 0; i < 3; i++) pv(1, 1000, 1, 10, 1, 0, 5, 4, 10, -10);
        pv(1, 1000, 1, 10, 1, 0, 5, 4, -100, 100, 0);
        pv(1, 1000, 1, 10, 1, 0, 5, 4, -100, 100, 0);
        pv(1, 1000, 1, 60, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(pack(3'd0, 14'd0, 16'd0));
        compare("reset_state");
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-SWEEP, checked before any clock edge.
        #2 rstn = 1'b0;
        #1;
        exp_q.push_back(pack(3'd0, 14'd0, 16'd0));
        compare("async_reset_now");
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(pack(3'd0, 14'd0, 16'd0));
        compare("reset_held");
        rstn = 1'b1;
        apply(mk(1, 1000, 1, -100, 0), "post_reset_enter");
        apply(mk(1, 1000, 1, -50, 0), "post_reset_step");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
